// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared types and constants for the AXI3-style read/write slave blocks.
//   - channel widths derived from the bus data width and the ARSIZE width
//   - burst type enum (FIXED/INCR/WRAP/RSVD)
//   - response codes OKAY and SLVERR
//   - read-slave FSM state enum (IDLE/BURST)
//   - clamp_size(): limits a requested beat size to the 4-byte data bus
// -----------------------------------------------------------------------------
package axi_pkg;

   localparam int AXI_WIDTH   = 32;
   localparam int AXI_SIZE    = 3;
   localparam int AXI_ID_W    = AXI_WIDTH / 8;
   localparam int AXI_LEN_W   = AXI_WIDTH / 8;
   localparam int AXI_BURST_W = AXI_SIZE - 1;
   localparam int AXI_RESP_W  = AXI_SIZE - 1;

   localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = AXI_RESP_W'(0);
   localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = AXI_RESP_W'(2);

   typedef enum logic [AXI_BURST_W-1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_t;

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   // The data bus is one 32-bit word, so anything wider than 4 bytes per
   // beat is served as a 4-byte beat.
   function automatic logic [1:0] clamp_size(input logic [AXI_SIZE-1:0] size);
      if (size > AXI_SIZE'(2)) begin
         return 2'd2;
      end
      return size[1:0];
   endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// -----------------------------------------------------------------------------
// axi_burst_addr
// Combinational next-beat address generator shared by the read and write
// slaves.
// Ports:
//   addr      in   current beat byte address
//   size      in   effective beat size, bytes = 2^size (already clamped)
//   len       in   burst length minus one
//   burst     in   burst type (FIXED, INCR, WRAP; RSVD behaves as INCR)
//   next_addr out  byte address of the following beat (modulo 2^WIDTH)
// -----------------------------------------------------------------------------
module axi_burst_addr
   import axi_pkg::*;
#(
   parameter int WIDTH = AXI_WIDTH,
   parameter int LEN_W = AXI_LEN_W
) (
   input  logic [WIDTH-1:0] addr,
   input  logic [1:0]       size,
   input  logic [LEN_W-1:0] len,
   input  burst_t           burst,
   output logic [WIDTH-1:0] next_addr
);

   logic [WIDTH-1:0] incr_addr;
   logic [WIDTH-1:0] wrap_mask;
   logic             wrap_ok;

   // A WRAP burst stays inside a window of (len+1)*2^size bytes aligned to
   // that size: the low bits follow the increment, the high bits stay at the
   // window base. Only power-of-two lengths form a valid window; any other
   // WRAP length, and the reserved type, fall back to plain increment.
   always_comb begin
      incr_addr = addr + (WIDTH'(1) << size);
      wrap_mask = ((WIDTH'(len) + WIDTH'(1)) << size) - WIDTH'(1);
      wrap_ok   = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                  (len == LEN_W'(7)) || (len == LEN_W'(15));
      next_addr = incr_addr;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP: begin
            if (wrap_ok) begin
               next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            end
         end
         default: next_addr = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_rd_slave.sv
// -----------------------------------------------------------------------------
// axi_rd_slave
// AXI3-style read-channel responder. Accepts one AR request at a time, walks
// the FIXED/INCR/WRAP beat sequence and returns words from an internal memory
// with RID, RRESP and RLAST. A backdoor write port preloads the memory.
// Optional build macro:
//   AXI_RD_SLV_ERR_EN  beats addressed at or beyond DEPTH*4 bytes return
//                      SLVERR with zero data; when undefined the word index
//                      wraps modulo DEPTH and the response is always OKAY.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   ARVALID/ARREADY             read address handshake
//   ARID, ARADDR, ARLEN,
//   ARSIZE, ARBURST             read address payload
//   RVALID/RREADY               read data handshake
//   RID, RDATA, RRESP, RLAST    read data payload
//   mem_we, mem_waddr, mem_wdata  backdoor memory write (any state)
// -----------------------------------------------------------------------------
module axi_rd_slave
   import axi_pkg::*;
#(
   parameter int WIDTH = AXI_WIDTH,
   parameter int SIZE  = AXI_SIZE,
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ARVALID,
   output logic                     ARREADY,
   input  logic [WIDTH/8-1:0]       ARID,
   input  logic [WIDTH-1:0]         ARADDR,
   input  logic [WIDTH/8-1:0]       ARLEN,
   input  logic [SIZE-1:0]          ARSIZE,
   input  logic [SIZE-2:0]          ARBURST,
   output logic                     RVALID,
   input  logic                     RREADY,
   output logic [WIDTH/8-1:0]       RID,
   output logic [WIDTH-1:0]         RDATA,
   output logic [SIZE-2:0]          RRESP,
   output logic                     RLAST,
   input  logic                     mem_we,
   input  logic [$clog2(DEPTH)-1:0] mem_waddr,
   input  logic [WIDTH-1:0]         mem_wdata
);

   localparam int ID_W   = WIDTH / 8;
   localparam int LEN_W  = WIDTH / 8;
   localparam int RESP_W = SIZE - 1;
   localparam int IDX_W  = $clog2(DEPTH);

   state_t             state;
   state_t             state_next;
   logic               ar_ready_q;
   logic               ar_hs;
   logic               r_hs;

   logic [WIDTH-1:0]   addr_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   cnt_q;
   logic [1:0]         size_q;
   burst_t             burst_q;
   logic [WIDTH-1:0]   next_addr;

   logic               rvalid_q;
   logic               rlast_q;
   logic [ID_W-1:0]    rid_q;
   logic [WIDTH-1:0]   rdata_q;
   logic [RESP_W-1:0]  rresp_q;

   logic [IDX_W-1:0]   load_idx;
   logic [WIDTH-1:0]   load_data;
   logic [RESP_W-1:0]  load_resp;

   logic [WIDTH-1:0]   mem [DEPTH];

   axi_burst_addr #(
      .WIDTH (WIDTH),
      .LEN_W (LEN_W)
   ) u_burst_addr (
      .addr      (addr_q),
      .size      (size_q),
      .len       (len_q),
      .burst     (burst_q),
      .next_addr (next_addr)
   );

   // ARREADY is held low during reset and for the first cycle after it,
   // then follows the IDLE state.
   assign ARREADY = (state == IDLE) && ar_ready_q;
   assign RVALID  = rvalid_q;
   assign RLAST   = rlast_q;
   assign RID     = rid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and handshake decode. The handshake on the RLAST beat
   // ends the burst so a new AR can be accepted the very next cycle.
   always_comb begin
      state_next = state;
      ar_hs      = 1'b0;
      r_hs       = 1'b0;
      case (state)
         IDLE: begin
            if (ARVALID && ar_ready_q) begin
               ar_hs      = 1'b1;
               state_next = BURST;
            end
         end
         BURST: begin
            if (rvalid_q && RREADY) begin
               r_hs = 1'b1;
               if (rlast_q) begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Word fetched for the beat being loaded: the first beat comes straight
   // from ARADDR, later beats from the generated next address. Byte lanes of
   // narrow beats are not shifted; the whole word is returned.
   always_comb begin
      load_idx  = ar_hs ? ARADDR[IDX_W+1:2] : next_addr[IDX_W+1:2];
      load_data = mem[load_idx];
      load_resp = RESP_OKAY;
`ifdef AXI_RD_SLV_ERR_EN
      if (ar_hs ? ((ARADDR >> (IDX_W + 2)) != '0)
                : ((next_addr >> (IDX_W + 2)) != '0)) begin
         load_data = '0;
         load_resp = RESP_SLVERR;
      end
`endif
   end

   // Burst context and registered R channel. Outputs only change on a load,
   // so they stay stable while the master stalls with RREADY low.
   always_ff @(posedge clk) begin
      if (reset) begin
         ar_ready_q <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         size_q     <= '0;
         burst_q    <= BURST_INCR;
         rvalid_q   <= 1'b0;
         rlast_q    <= 1'b0;
         rid_q      <= '0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         ar_ready_q <= 1'b1;
         if (ar_hs) begin
            addr_q   <= ARADDR;
            len_q    <= ARLEN;
            cnt_q    <= '0;
            size_q   <= clamp_size(ARSIZE);
            burst_q  <= burst_t'(ARBURST);
            rid_q    <= ARID;
            rvalid_q <= 1'b1;
            rlast_q  <= (ARLEN == '0);
            rdata_q  <= load_data;
            rresp_q  <= load_resp;
         end else if (r_hs) begin
            if (rlast_q) begin
               rvalid_q <= 1'b0;
               rlast_q  <= 1'b0;
            end else begin
               addr_q  <= next_addr;
               cnt_q   <= cnt_q + LEN_W'(1);
               rlast_q <= ((cnt_q + LEN_W'(1)) == len_q);
               rdata_q <= load_data;
               rresp_q <= load_resp;
            end
         end
      end
   end

   // Backdoor port. Kept out of reset so preloaded contents survive it; the
   // beat load above sees the pre-write value on a same-cycle write.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

endmodule

// File: tb/tb_axi_rd_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_rd_slave
// Directed bench for axi_rd_slave. Memory word i is preloaded with
// 32'hC0DE_0000 | i so every expected beat value is known up front.
// Honours AXI_RD_SLV_ERR_EN for the out-of-range boundary scenario.
// -----------------------------------------------------------------------------
module tb_axi_rd_slave;
   import axi_pkg::*;

   localparam int WIDTH = 32;
   localparam int SIZE  = 3;
   localparam int DEPTH = 256;

   logic              clk = 1'b0;
   logic              reset;
   logic              ARVALID;
   logic              ARREADY;
   logic [3:0]        ARID;
   logic [31:0]       ARADDR;
   logic [3:0]        ARLEN;
   logic [2:0]        ARSIZE;
   logic [1:0]        ARBURST;
   logic              RVALID;
   logic              RREADY;
   logic [3:0]        RID;
   logic [31:0]       RDATA;
   logic [1:0]        RRESP;
   logic              RLAST;
   logic              mem_we;
   logic [7:0]        mem_waddr;
   logic [31:0]       mem_wdata;

   int                checks   = 0;
   int                failures = 0;
   logic [31:0]       exp_data [16];
   logic [1:0]        exp_resp [16];

   axi_rd_slave #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ARVALID   (ARVALID),
      .ARREADY   (ARREADY),
      .ARID      (ARID),
      .ARADDR    (ARADDR),
      .ARLEN     (ARLEN),
      .ARSIZE    (ARSIZE),
      .ARBURST   (ARBURST),
      .RVALID    (RVALID),
      .RREADY    (RREADY),
      .RID       (RID),
      .RDATA     (RDATA),
      .RRESP     (RRESP),
      .RLAST     (RLAST),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   function automatic logic [31:0] word_val(input int w);
      return 32'hC0DE_0000 | 32'(w);
   endfunction

   // Advance one cycle and settle just past the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one AR with RREADY held high and check every beat against
   // exp_data/exp_resp, then the return to idle.
   task automatic run_burst(input string name, input logic [3:0] id,
                            input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
      checks++;
      if (ARREADY !== 1'b1) begin
         failures++;
         $display("FAIL %s arready_idle got=%b exp=1", name, ARREADY);
      end
      ARVALID = 1'b1;
      ARID    = id;
      ARADDR  = addr;
      ARLEN   = len;
      ARSIZE  = size;
      ARBURST = burst;
      RREADY  = 1'b1;
      tick();
      ARVALID = 1'b0;
      checks++;
      if (ARREADY !== 1'b0) begin
         failures++;
         $display("FAIL %s arready_busy got=%b exp=0", name, ARREADY);
      end
      for (int b = 0; b <= int'(len); b++) begin
         checks++;
         if (RVALID !== 1'b1) begin
            failures++;
            $display("FAIL %s rvalid beat=%0d got=%b exp=1", name, b, RVALID);
         end
         checks++;
         if (RDATA !== exp_data[b]) begin
            failures++;
            $display("FAIL %s rdata beat=%0d got=%h exp=%h", name, b, RDATA, exp_data[b]);
         end
         checks++;
         if (RRESP !== exp_resp[b]) begin
            failures++;
            $display("FAIL %s rresp beat=%0d got=%0d exp=%0d", name, b, RRESP, exp_resp[b]);
         end
         checks++;
         if (RID !== id) begin
            failures++;
            $display("FAIL %s rid beat=%0d got=%0d exp=%0d", name, b, RID, id);
         end
         checks++;
         if (RLAST !== (b == int'(len))) begin
            failures++;
            $display("FAIL %s rlast beat=%0d got=%b exp=%b", name, b, RLAST, (b == int'(len)));
         end
         tick();
      end
      checks++;
      if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
         failures++;
         $display("FAIL %s end_idle got rvalid=%b arready=%b exp rvalid=0 arready=1",
                  name, RVALID, ARREADY);
      end
   endtask

   task automatic set_exp(input int idx, input int word, input logic [1:0] resp);
      exp_data[idx] = word_val(word);
      exp_resp[idx] = resp;
   endtask

   // Reset values, then ARREADY rising one clock after reset is released.
   task automatic test_reset();
      reset     = 1'b1;
      ARVALID   = 1'b0;
      ARID      = '0;
      ARADDR    = '0;
      ARLEN     = '0;
      ARSIZE    = '0;
      ARBURST   = '0;
      RREADY    = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      tick();
      tick();
      checks++;
      if (ARREADY !== 1'b0 || RVALID !== 1'b0 || RLAST !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl got arready=%b rvalid=%b rlast=%b exp all 0",
                  ARREADY, RVALID, RLAST);
      end
      checks++;
      if (RID !== 4'd0 || RDATA !== 32'd0 || RRESP !== 2'd0) begin
         failures++;
         $display("FAIL reset_data got rid=%0d rdata=%h rresp=%0d exp all 0", RID, RDATA, RRESP);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (ARREADY !== 1'b1) begin
         failures++;
         $display("FAIL reset_release arready got=%b exp=1", ARREADY);
      end
   endtask

   task automatic preload();
      for (int i = 0; i < DEPTH; i++) begin
         mem_we    = 1'b1;
         mem_waddr = 8'(i);
         mem_wdata = word_val(i);
         tick();
      end
      mem_we = 1'b0;
   endtask

   task automatic test_incr();
      for (int b = 0; b < 4; b++) set_exp(b, b, RESP_OKAY);
      run_burst("incr", 4'd5, 32'h0, 4'd3, 3'd2, 2'd1);
      // ARSIZE 5 is served as 4-byte beats
      set_exp(0, 8, RESP_OKAY);
      set_exp(1, 9, RESP_OKAY);
      run_burst("incr_clamp", 4'd6, 32'h20, 4'd1, 3'd5, 2'd1);
      // byte beats at 4..7 all sit in word 1
      for (int b = 0; b < 4; b++) set_exp(b, 1, RESP_OKAY);
      run_burst("incr_narrow", 4'd1, 32'h4, 4'd3, 3'd0, 2'd1);
      // reserved burst type behaves as INCR
      set_exp(0, 12, RESP_OKAY);
      set_exp(1, 13, RESP_OKAY);
      run_burst("rsvd", 4'd14, 32'h30, 4'd1, 3'd2, 2'd3);
   endtask

   task automatic test_wrap();
      set_exp(0, 2, RESP_OKAY);
      set_exp(1, 3, RESP_OKAY);
      set_exp(2, 0, RESP_OKAY);
      set_exp(3, 1, RESP_OKAY);
      run_burst("wrap", 4'd3, 32'h8, 4'd3, 3'd2, 2'd2);
      // LEN 2 is not a wrap length, so it increments 2,3,4
      set_exp(0, 2, RESP_OKAY);
      set_exp(1, 3, RESP_OKAY);
      set_exp(2, 4, RESP_OKAY);
      run_burst("wrap_len2", 4'd4, 32'h8, 4'd2, 3'd2, 2'd2);
   endtask

   task automatic test_fixed();
      for (int b = 0; b < 3; b++) set_exp(b, 1, RESP_OKAY);
      run_burst("fixed", 4'd10, 32'h4, 4'd2, 3'd2, 2'd0);
   endtask

   // RREADY low for three cycles on beat 0: payload must hold.
   task automatic test_stall();
      RREADY  = 1'b0;
      ARVALID = 1'b1;
      ARID    = 4'd7;
      ARADDR  = 32'h10;
      ARLEN   = 4'd1;
      ARSIZE  = 3'd2;
      ARBURST = 2'd1;
      tick();
      ARVALID = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (RVALID !== 1'b1 || RDATA !== word_val(4) || RLAST !== 1'b0 || RID !== 4'd7) begin
            failures++;
            $display("FAIL stall_hold cycle=%0d got v=%b d=%h l=%b id=%0d exp v=1 d=%h l=0 id=7",
                     c, RVALID, RDATA, RLAST, RID, word_val(4));
         end
         tick();
      end
      RREADY = 1'b1;
      tick();
      checks++;
      if (RVALID !== 1'b1 || RDATA !== word_val(5) || RLAST !== 1'b1) begin
         failures++;
         $display("FAIL stall_beat1 got v=%b d=%h l=%b exp v=1 d=%h l=1",
                  RVALID, RDATA, RLAST, word_val(5));
      end
      tick();
      checks++;
      if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
         failures++;
         $display("FAIL stall_end got rvalid=%b arready=%b exp rvalid=0 arready=1", RVALID, ARREADY);
      end
   endtask

   // INCR from 0x3F8 crosses the top of the 1 KiB memory on beat 2.
   task automatic test_boundary();
      set_exp(0, 254, RESP_OKAY);
      set_exp(1, 255, RESP_OKAY);
`ifdef AXI_RD_SLV_ERR_EN
      exp_data[2] = 32'd0;
      exp_resp[2] = RESP_SLVERR;
      exp_data[3] = 32'd0;
      exp_resp[3] = RESP_SLVERR;
`else
      set_exp(2, 0, RESP_OKAY);
      set_exp(3, 1, RESP_OKAY);
`endif
      run_burst("boundary", 4'd8, 32'h3F8, 4'd3, 3'd2, 2'd1);
   endtask

   // Reset asserted while beat 2 of an 8-beat burst is presented.
   task automatic test_reset_mid();
      RREADY  = 1'b1;
      ARVALID = 1'b1;
      ARID    = 4'd11;
      ARADDR  = 32'h0;
      ARLEN   = 4'd7;
      ARSIZE  = 3'd2;
      ARBURST = 2'd1;
      tick();
      ARVALID = 1'b0;
      tick();
      tick();
      checks++;
      if (RVALID !== 1'b1 || RDATA !== word_val(2)) begin
         failures++;
         $display("FAIL midrst_beat2 got v=%b d=%h exp v=1 d=%h", RVALID, RDATA, word_val(2));
      end
      reset = 1'b1;
      tick();
      checks++;
      if (RVALID !== 1'b0 || ARREADY !== 1'b0 || RLAST !== 1'b0 || RDATA !== 32'd0 || RID !== 4'd0) begin
         failures++;
         $display("FAIL midrst_abort got v=%b ar=%b l=%b d=%h id=%0d exp all 0",
                  RVALID, ARREADY, RLAST, RDATA, RID);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (ARREADY !== 1'b1 || RVALID !== 1'b0) begin
         failures++;
         $display("FAIL midrst_ready got arready=%b rvalid=%b exp arready=1 rvalid=0", ARREADY, RVALID);
      end
      set_exp(0, 7, RESP_OKAY);
      run_burst("midrst_single", 4'd9, 32'h1C, 4'd0, 3'd2, 2'd1);
   endtask

   // Backdoor write to word 1 on the same edge that loads beat 1.
   task automatic test_read_before_write();
      RREADY  = 1'b1;
      ARVALID = 1'b1;
      ARID    = 4'd2;
      ARADDR  = 32'h0;
      ARLEN   = 4'd1;
      ARSIZE  = 3'd2;
      ARBURST = 2'd1;
      tick();
      ARVALID = 1'b0;
      checks++;
      if (RDATA !== word_val(0)) begin
         failures++;
         $display("FAIL rbw_beat0 got=%h exp=%h", RDATA, word_val(0));
      end
      mem_we    = 1'b1;
      mem_waddr = 8'd1;
      mem_wdata = 32'h1234_5678;
      tick();
      mem_we = 1'b0;
      checks++;
      if (RDATA !== word_val(1) || RLAST !== 1'b1) begin
         failures++;
         $display("FAIL rbw_old got d=%h l=%b exp d=%h l=1", RDATA, RLAST, word_val(1));
      end
      tick();
      checks++;
      if (RVALID !== 1'b0) begin
         failures++;
         $display("FAIL rbw_end rvalid got=%b exp=0", RVALID);
      end
      exp_data[0] = 32'h1234_5678;
      exp_resp[0] = RESP_OKAY;
      run_burst("rbw_reread", 4'd2, 32'h4, 4'd0, 3'd2, 2'd1);
   endtask

   // Scenario sequence.
   initial begin
      test_reset();
      preload();
      test_incr();
      test_wrap();
      test_fixed();
      test_stall();
      test_boundary();
      test_reset_mid();
      test_read_before_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a hung run.
   initial begin
      #100000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
